// File: rtl/fetch_pc_gen_pkg.sv
// Shared opcode constants, FSM state type and immediate extractors for the fetch PC generator.
package fetch_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_JWAIT = 2'd1,
        ST_PEND  = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] imm_i(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:20]};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    // x1 and x5 are the conventional link registers for call/return hints
    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

endpackage

// File: rtl/fetch_predecode.sv
// Per-slot predecode: classifies one instruction as jal/jalr/branch and forms its static targets.
module fetch_predecode
    import fetch_pkg::*;
#(
    parameter int PC_W = 64
) (
    input  logic [31:0]     inst,
    input  logic [PC_W-1:0] slot_pc,
    output logic            is_jal,
    output logic            is_jalr,
    output logic            is_br,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [PC_W-1:0] rel_target,
    output logic [PC_W-1:0] jalr_imm
);

    logic signed [31:0] i_s;
    logic signed [31:0] j_s;
    logic signed [31:0] b_s;

    assign i_s = imm_i(inst);
    assign j_s = imm_j(inst);
    assign b_s = imm_b(inst);

    assign is_jal  = (inst[6:0] == OPC_JAL);
    assign is_jalr = (inst[6:0] == OPC_JALR);
    assign is_br   = (inst[6:0] == OPC_BRANCH);
    assign rd      = inst[11:7];
    assign rs1     = inst[19:15];

    assign rel_target = slot_pc + (is_jal ? PC_W'(j_s) : PC_W'(b_s));
    assign jalr_imm   = PC_W'(i_s);

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: aligned-group fetch, predecode-based next PC, redirects, jalr operand wait.
// Optional return-address stack enabled by defining FETCH_PC_GEN_RAS_EN.
//
// state    | meaning
// ST_RUN   | normal fetch, next PC chosen from predecode or redirect
// ST_JWAIT | taken jalr waiting for its base register, fetch stalled
// ST_PEND  | redirect latched while the cache stalls, flush on ready
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int          FETCH_W   = 4,
    parameter int          PC_W      = 64,
    parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
    parameter int          NUM_REDIR = 3,
    parameter int          RAS_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       fetch_valid,
    input  logic                       fetch_ready,
    output logic [PC_W-1:0]            fetch_pc,
    output logic [FETCH_W-1:0]         fetch_mask,
    output logic [$clog2(FETCH_W):0]   fetch_cnt,
    output logic                       fetch_flush,
    input  logic [32*FETCH_W-1:0]      inst_i,
    input  logic [NUM_REDIR-1:0]       redir_valid,
    input  logic [NUM_REDIR*PC_W-1:0]  redir_pc,
    output logic [3:0]                 bht_idx,
    input  logic                       bht_taken,
    output logic                       jreg_req,
    output logic [4:0]                 jreg_addr,
    input  logic                       jreg_valid,
    input  logic [PC_W-1:0]            jreg_data
);

    localparam int OFF_W = $clog2(FETCH_W);
    localparam int CNT_W = OFF_W + 1;
    localparam int RC_W  = $clog2(RAS_DEPTH + 1);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pend_q, pend_d;
    logic [PC_W-1:0] jw_imm_q, jw_imm_d;
    logic [4:0]      jw_rs1_q, jw_rs1_d;

    logic [OFF_W-1:0] off;
    logic [PC_W-1:0]  base;
    logic [PC_W-1:0]  slot_pc    [FETCH_W];
    logic [PC_W-1:0]  rel_target [FETCH_W];
    logic [PC_W-1:0]  jalr_imm   [FETCH_W];
    logic [4:0]       rd_s       [FETCH_W];
    logic [4:0]       rs1_s      [FETCH_W];
    logic [FETCH_W-1:0] is_jal, is_jalr, is_br;

    assign off      = pc_q[OFF_W+1:2];
    assign base     = {pc_q[PC_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
    assign fetch_pc = pc_q;

    for (genvar k = 0; k < FETCH_W; k++) begin : g_slot
        assign slot_pc[k] = base + PC_W'(4 * k);

        fetch_predecode #(.PC_W(PC_W)) u_predecode (
            .inst       (inst_i[32*k +: 32]),
            .slot_pc    (slot_pc[k]),
            .is_jal     (is_jal[k]),
            .is_jalr    (is_jalr[k]),
            .is_br      (is_br[k]),
            .rd         (rd_s[k]),
            .rs1        (rs1_s[k]),
            .rel_target (rel_target[k]),
            .jalr_imm   (jalr_imm[k])
        );
    end

    logic             br_found, tk_found;
    logic [OFF_W-1:0] br_slot, tk_slot;
    logic [CNT_W-1:0] cnt;

    // only the first branch at/after the offset gets a BHT lookup; later branches fall through
    always_comb begin
        br_found   = 1'b0;
        br_slot    = '0;
        tk_found   = 1'b0;
        tk_slot    = '0;
        fetch_mask = '0;
        cnt        = '0;
        for (int k = 0; k < FETCH_W; k++) begin
            if (k >= int'(off)) begin
                if (!tk_found && (is_jal[k] || is_jalr[k] || (is_br[k] && !br_found && bht_taken))) begin
                    tk_found = 1'b1;
                    tk_slot  = OFF_W'(k);
                end
                if (is_br[k] && !br_found) begin
                    br_found = 1'b1;
                    br_slot  = OFF_W'(k);
                end
            end
        end
        for (int k = 0; k < FETCH_W; k++) begin
            fetch_mask[k] = (k >= int'(off)) && (!tk_found || (k <= int'(tk_slot)));
            cnt = cnt + CNT_W'(fetch_mask[k]);
        end
    end

    assign fetch_cnt = cnt;
    assign bht_idx   = br_found ? slot_pc[br_slot][5:2] : 4'd0;

    logic            tk_jalr;
    logic [4:0]      tk_rs1, tk_rd;
    logic [PC_W-1:0] tk_rel, tk_imm;

    assign tk_jalr = tk_found && is_jalr[tk_slot];
    assign tk_rs1  = rs1_s[tk_slot];
    assign tk_rd   = rd_s[tk_slot];
    assign tk_rel  = rel_target[tk_slot];
    assign tk_imm  = jalr_imm[tk_slot];

    logic            redir_any;
    logic [PC_W-1:0] redir_tgt;

    always_comb begin
        redir_tgt = '0;
        for (int i = NUM_REDIR - 1; i >= 0; i--) begin
            if (redir_valid[i]) redir_tgt = redir_pc[i*PC_W +: PC_W];
        end
    end
    assign redir_any = |redir_valid;

    logic accept;
    assign fetch_valid = (state_q != ST_JWAIT);
    assign fetch_flush = fetch_ready && (((state_q == ST_RUN) && redir_any) || (state_q == ST_PEND));
    assign accept      = fetch_valid && fetch_ready && !fetch_flush;

    logic [RC_W-1:0] ras_cnt;
    logic [PC_W-1:0] ras_top;
    logic            ras_pop_ok;
    logic [PC_W-1:0] jalr_sum_now, jalr_sum_wait;

    assign ras_pop_ok    = tk_jalr && is_link(tk_rs1) && !is_link(tk_rd) && (ras_cnt != '0);
    assign jalr_sum_now  = jreg_data + tk_imm;
    assign jalr_sum_wait = jreg_data + jw_imm_q;

`ifdef FETCH_PC_GEN_RAS_EN
    localparam int RP_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [PC_W-1:0] ras_mem [RAS_DEPTH];
    logic [RP_W-1:0] ras_ptr_q;
    logic [RC_W-1:0] ras_cnt_q;
    logic [RP_W-1:0] ras_top_idx, ras_ptr_inc;
    logic            ras_push, ras_pop;
    logic [PC_W-1:0] tk_link;

    assign ras_top_idx = (ras_ptr_q == '0) ? RP_W'(RAS_DEPTH - 1) : ras_ptr_q - 1'b1;
    assign ras_ptr_inc = (ras_ptr_q == RP_W'(RAS_DEPTH - 1)) ? '0 : ras_ptr_q + 1'b1;
    assign ras_top     = ras_mem[ras_top_idx];
    assign ras_cnt     = ras_cnt_q;
    assign tk_link     = slot_pc[tk_slot] + PC_W'(4);
    assign ras_push    = accept && tk_found && (is_jal[tk_slot] || tk_jalr) && is_link(tk_rd);
    assign ras_pop     = accept && ras_pop_ok;

    // pointer names the next write slot; a push when full silently overwrites the oldest entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else if (redir_any) begin
            ras_cnt_q <= '0;
        end else if (ras_push) begin
            ras_ptr_q <= ras_ptr_inc;
            if (ras_cnt_q != RC_W'(RAS_DEPTH)) ras_cnt_q <= ras_cnt_q + 1'b1;
        end else if (ras_pop) begin
            ras_ptr_q <= ras_top_idx;
            ras_cnt_q <= ras_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ras_push) ras_mem[ras_ptr_q] <= tk_link;
    end
`else
    assign ras_cnt = '0;
    assign ras_top = '0;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_d    = pend_q;
        jw_imm_d  = jw_imm_q;
        jw_rs1_d  = jw_rs1_q;
        jreg_req  = 1'b0;
        jreg_addr = jw_rs1_q;
        case (state_q)
            ST_RUN: begin
                if (redir_any) begin
                    if (fetch_ready) begin
                        pc_d = redir_tgt;
                    end else begin
                        state_d = ST_PEND;
                        pend_d  = redir_tgt;
                    end
                end else if (accept) begin
                    if (!tk_found) begin
                        pc_d = base + PC_W'(4 * FETCH_W);
                    end else if (!tk_jalr) begin
                        pc_d = tk_rel;
                    end else if (ras_pop_ok) begin
                        pc_d = ras_top;
                    end else begin
                        jreg_req  = 1'b1;
                        jreg_addr = tk_rs1;
                        if (jreg_valid) begin
                            pc_d = {jalr_sum_now[PC_W-1:1], 1'b0};
                        end else begin
                            state_d  = ST_JWAIT;
                            jw_imm_d = tk_imm;
                            jw_rs1_d = tk_rs1;
                        end
                    end
                end
            end
            ST_JWAIT: begin
                jreg_req = 1'b1;
                if (redir_any) begin
                    pc_d    = redir_tgt;
                    state_d = ST_RUN;
                end else if (jreg_valid) begin
                    pc_d    = {jalr_sum_wait[PC_W-1:1], 1'b0};
                    state_d = ST_RUN;
                end
            end
            ST_PEND: begin
                if (redir_any) pend_d = redir_tgt;
                if (fetch_ready) begin
                    pc_d    = redir_any ? redir_tgt : pend_q;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            pc_q     <= PC_W'(RESET_PC);
            pend_q   <= '0;
            jw_imm_q <= '0;
            jw_rs1_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pend_q   <= pend_d;
            jw_imm_q <= jw_imm_d;
            jw_rs1_q <= jw_rs1_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen (FETCH_W=4, PC_W=64, RAS_DEPTH=2); RAS checks follow FETCH_PC_GEN_RAS_EN.
module tb_fetch_pc_gen;

    localparam int FW = 4;
    localparam int PW = 64;
    localparam int NR = 3;

    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [31:0] JAL_X0    = 32'h1000_006F;  // jal x0, +0x100
    localparam logic [31:0] JAL_X1    = 32'h1000_00EF;  // jal x1, +0x100
    localparam logic [31:0] JALR_X5_8 = 32'h0082_8067;  // jalr x0, 8(x5)
    localparam logic [31:0] RET       = 32'h0000_8067;  // jalr x0, 0(x1)
    localparam logic [31:0] BEQ_20    = 32'h0200_0063;  // beq x0, x0, +0x20

`ifdef FETCH_PC_GEN_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               fetch_valid;
    logic               fetch_ready;
    logic [PW-1:0]      fetch_pc;
    logic [FW-1:0]      fetch_mask;
    logic [2:0]         fetch_cnt;
    logic               fetch_flush;
    logic [32*FW-1:0]   inst_i;
    logic [NR-1:0]      redir_valid;
    logic [NR*PW-1:0]   redir_pc;
    logic [3:0]         bht_idx;
    logic               bht_taken;
    logic               jreg_req;
    logic [4:0]         jreg_addr;
    logic               jreg_valid;
    logic [PW-1:0]      jreg_data;

    fetch_pc_gen #(
        .FETCH_W   (FW),
        .PC_W      (PW),
        .RESET_PC  (64'h0000_0000_8000_0000),
        .NUM_REDIR (NR),
        .RAS_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .fetch_pc    (fetch_pc),
        .fetch_mask  (fetch_mask),
        .fetch_cnt   (fetch_cnt),
        .fetch_flush (fetch_flush),
        .inst_i      (inst_i),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .bht_idx     (bht_idx),
        .bht_taken   (bht_taken),
        .jreg_req    (jreg_req),
        .jreg_addr   (jreg_addr),
        .jreg_valid  (jreg_valid),
        .jreg_data   (jreg_data)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] grp(input logic [31:0] s0, input logic [31:0] s1,
                                         input logic [31:0] s2, input logic [31:0] s3);
        return {s3, s2, s1, s0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        fetch_ready = 1'b1;
        redir_valid = '0;
        redir_pc    = '0;
        bht_taken   = 1'b0;
        jreg_valid  = 1'b0;
        jreg_data   = '0;
        inst_i      = grp(NOP, NOP, NOP, NOP);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [63:0] ret_exp [3];
    int          jw_cycles;

    initial begin
        rst = 1'b1;
        quiet();
        #2;
        chk("rst_pc", fetch_pc, 64'h8000_0000);
        chk("rst_flush", fetch_flush, 0);
        chk("rst_jreq", jreg_req, 0);
        #10 rst = 1'b0;
        #1;
        chk("rel_valid", fetch_valid, 1);
        chk("nop_cnt0", fetch_cnt, 4);
        chk("nop_mask0", fetch_mask, 4'b1111);
        step();
        chk("nop_pc1", fetch_pc, 64'h8000_0010);
        step();
        chk("nop_pc2", fetch_pc, 64'h8000_0020);
        chk("nop_cnt2", fetch_cnt, 4);

        // redirect to an unaligned PC, then jal in slot 2
        redir_valid = 3'b100;
        redir_pc[2*PW +: PW] = 64'h8000_0008;
        #1;
        chk("redir_flush", fetch_flush, 1);
        step();
        quiet();
        chk("redir_pc", fetch_pc, 64'h8000_0008);
        inst_i = grp(NOP, NOP, JAL_X0, NOP);
        #1;
        chk("jal_mask", fetch_mask, 4'b0100);
        chk("jal_cnt", fetch_cnt, 1);
        step();
        chk("jal_pc", fetch_pc, 64'h8000_0108);
        inst_i = grp(NOP, NOP, NOP, BEQ_20);
        #1;
        chk("ntk_cnt", fetch_cnt, 2);
        chk("ntk_mask", fetch_mask, 4'b1100);
        chk("ntk_bht_idx", bht_idx, 4'd3);
        step();
        chk("ntk_pc", fetch_pc, 64'h8000_0110);
        inst_i = grp(NOP, BEQ_20, NOP, JAL_X0);
        bht_taken = 1'b1;
        #1;
        chk("tk_bht_idx", bht_idx, 4'd5);
        chk("tk_mask", fetch_mask, 4'b0011);
        step();
        bht_taken = 1'b0;
        chk("tk_pc", fetch_pc, 64'h8000_0134);

        // jalr waits for its base register
        inst_i = grp(NOP, JALR_X5_8, NOP, NOP);
        #1;
        chk("jalr_mask", fetch_mask, 4'b0010);
        chk("jalr_req", jreg_req, 1);
        chk("jalr_addr", jreg_addr, 5);
        step();
        inst_i = grp(NOP, NOP, NOP, NOP);
        jw_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            if (!fetch_valid && jreg_req) jw_cycles++;
            chk("jwait_pc_hold", fetch_pc, 64'h8000_0134);
            if (i == 2) begin
                jreg_valid = 1'b1;
                jreg_data  = 64'h8000_1001;
            end
            step();
        end
        jreg_valid = 1'b0;
        chk("jwait_cycles", jw_cycles, 3);
        chk("jalr_pc", fetch_pc, 64'h8000_1008);
        chk("jalr_valid", fetch_valid, 1);

        // redirect under stall goes pending; later redirect overwrites it
        fetch_ready = 1'b0;
        redir_valid = 3'b100;
        redir_pc[2*PW +: PW] = 64'h9000;
        #1;
        chk("pend_noflush", fetch_flush, 0);
        step();
        redir_valid = 3'b001;
        redir_pc[0 +: PW] = 64'hA000;
        #1;
        chk("pend_hold_pc", fetch_pc, 64'h8000_1008);
        chk("pend_valid", fetch_valid, 1);
        step();
        redir_valid = '0;
        fetch_ready = 1'b1;
        #1;
        chk("pend_flush", fetch_flush, 1);
        step();
        chk("pend_pc", fetch_pc, 64'hA000);

        // simultaneous redirects: lowest index wins
        redir_valid = 3'b110;
        redir_pc[1*PW +: PW] = 64'hB000;
        redir_pc[2*PW +: PW] = 64'hC000;
        step();
        redir_valid = '0;
        chk("prio_pc", fetch_pc, 64'hB000);
        fetch_ready = 1'b0;
        step();
        chk("stall_pc", fetch_pc, 64'hB000);
        fetch_ready = 1'b1;
        step();
        chk("unstall_pc", fetch_pc, 64'hB010);

        // PC wraps modulo 2^64
        redir_valid = 3'b001;
        redir_pc[0 +: PW] = 64'hFFFF_FFFF_FFFF_FFF8;
        step();
        redir_valid = '0;
        #1;
        chk("wrap_cnt", fetch_cnt, 2);
        step();
        chk("wrap_pc", fetch_pc, 64'h0);

        // reset while pending abandons the redirect
        fetch_ready = 1'b0;
        redir_valid = 3'b001;
        redir_pc[0 +: PW] = 64'hD000;
        step();
        redir_valid = '0;
        fetch_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_pend_pc", fetch_pc, 64'h8000_0000);
        chk("rst_pend_flush", fetch_flush, 0);
        #2 rst = 1'b0;
        #1;
        chk("rst_pend_valid", fetch_valid, 1);

        // three nested calls, then three returns
        for (int i = 0; i < 3; i++) begin
            inst_i = grp(JAL_X1, NOP, NOP, NOP);
            step();
            chk("call_pc", fetch_pc, 64'h8000_0000 + 64'h100 * (i + 1));
        end
        ret_exp[0] = 64'h8000_0204;
        ret_exp[1] = 64'h8000_0104;
        ret_exp[2] = 64'h8000_0004;
        for (int i = 0; i < 3; i++) begin
            logic pop_exp;
            int   sl;
            pop_exp = RAS_ON && (i < 2);
            sl = int'(fetch_pc[3:2]);
            inst_i = grp(NOP, NOP, NOP, NOP);
            inst_i[32*sl +: 32] = RET;
            jreg_valid = 1'b1;
            jreg_data  = pop_exp ? 64'hDEAD_0000 : ret_exp[i];
            #1;
            chk("ret_jreq", jreg_req, !pop_exp);
            step();
            chk("ret_pc", fetch_pc, ret_exp[i]);
        end
        quiet();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
